// File: rtl/hello_display_sequencer.sv
// rtl/hello_display_sequencer.sv - HELLO text sequencer for five 7-segment digits (optional FREEZE input: HELLO_SEQ_FREEZE_EN)
module hello_display_sequencer #(
    parameter int TICK_DIV         = 25000000,
    parameter int DEMO_BLINK_TICKS = 6
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] SW,
`ifdef HELLO_SEQ_FREEZE_EN
    input  logic       FREEZE,
`endif
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3,
    output logic [0:6] HEX4
);

    localparam int STEP_W = (DEMO_BLINK_TICKS > 2) ? $clog2(DEMO_BLINK_TICKS) : 1;
    localparam logic [25:0]       DIV       = 26'(TICK_DIV);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DEMO_BLINK_TICKS - 1);

    // Active-low glyphs, bit 0 = segment a.
    localparam logic [0:6] G_H     = 7'b1001000;
    localparam logic [0:6] G_E     = 7'b0110000;
    localparam logic [0:6] G_L     = 7'b1110001;
    localparam logic [0:6] G_O     = 7'b0000001;
    localparam logic [0:6] G_BLANK = 7'b1111111;

    typedef enum logic [2:0] {
        ST_STATIC,
        ST_BLINK,
        ST_SCROLL,
        ST_DEMO_SCROLL,
        ST_DEMO_BLINK
    } state_t;

    // Eight-slot message ring: H E L L O followed by three blanks.
    function automatic logic [0:6] ring_glyph(input logic [2:0] idx);
        case (idx)
            3'd0:    ring_glyph = G_H;
            3'd1:    ring_glyph = G_E;
            3'd2:    ring_glyph = G_L;
            3'd3:    ring_glyph = G_L;
            3'd4:    ring_glyph = G_O;
            default: ring_glyph = G_BLANK;
        endcase
    endfunction

    logic [3:0]        sw_q;
    logic [3:0]        sw_prev_q;
    logic [25:0]       cnt_q, cnt_d;
    logic [25:0]       limit;
    logic              tick;
    logic              sw_chg;
    logic              mode_chg;
    logic              hold;
    state_t            state_q, state_d;
    logic [2:0]        pos_q, pos_d;
    logic              vis_q, vis_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              live_q;
    logic [0:6]        hex_q [5];
    logic [0:6]        hex_d [5];

`ifdef HELLO_SEQ_FREEZE_EN
    assign hold = FREEZE;
`else
    assign hold = 1'b0;
`endif

    // Prescaler: tick on reaching the speed-dependent limit; any switch change restarts the count.
    always_comb begin
        limit    = (DIV >> sw_q[1:0]) - 26'd1;
        sw_chg   = (sw_q != sw_prev_q);
        mode_chg = (sw_q[3:2] != sw_prev_q[3:2]);
        tick     = !hold && !sw_chg && (cnt_q == limit);
        cnt_d    = cnt_q + 26'd1;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (sw_chg || tick) begin
            cnt_d = 26'd0;
        end
    end

    // Next state: a pending mode change beats a tick; a freeze holds everything.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vis_d   = vis_q;
        step_d  = step_q;
        if (hold) begin
            state_d = state_q;
        end else if (mode_chg) begin
            pos_d  = 3'd0;
            vis_d  = 1'b1;
            step_d = '0;
            case (sw_q[3:2])
                2'b00:   state_d = ST_STATIC;
                2'b01:   state_d = ST_BLINK;
                2'b10:   state_d = ST_SCROLL;
                default: state_d = ST_DEMO_SCROLL;
            endcase
        end else if (tick) begin
            case (state_q)
                ST_BLINK:  vis_d = !vis_q;
                ST_SCROLL: pos_d = pos_q + 3'd1;
                ST_DEMO_SCROLL: begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd7) begin
                        state_d = ST_DEMO_BLINK;
                        step_d  = '0;
                        vis_d   = 1'b1;
                    end
                end
                ST_DEMO_BLINK: begin
                    vis_d  = !vis_q;
                    step_d = step_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        state_d = ST_DEMO_SCROLL;
                        vis_d   = 1'b1;
                        pos_d   = 3'd0;
                        step_d  = '0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output decode: window onto the ring, dark until the first post-reset cycle has passed.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            hex_d[k] = (live_q && vis_q) ? ring_glyph(pos_q + 3'd4 - 3'(k)) : G_BLANK;
        end
    end

    // State register: switch sampling, prescaler and FSM; the previous-switch copy waits out a freeze.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sw_q      <= 4'd0;
            sw_prev_q <= 4'd0;
            cnt_q     <= 26'd0;
            state_q   <= ST_STATIC;
            pos_q     <= 3'd0;
            vis_q     <= 1'b1;
            step_q    <= '0;
            live_q    <= 1'b0;
        end else begin
            sw_q <= SW;
            if (!hold) begin
                sw_prev_q <= sw_q;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            vis_q   <= vis_d;
            step_q  <= step_d;
            live_q  <= 1'b1;
        end
    end

    // Segment output registers.
    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < 5; k++) begin
            if (RESET) begin
                hex_q[k] <= G_BLANK;
            end else begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];

endmodule

// File: tb/tb_hello_display_sequencer.sv
// tb/tb_hello_display_sequencer.sv - self-checking bench for hello_display_sequencer
module tb_hello_display_sequencer;

    localparam int TDIV = 16;
    localparam int DBT  = 6;

    localparam logic [6:0] G_H = 7'b1001000;
    localparam logic [6:0] G_E = 7'b0110000;
    localparam logic [6:0] G_L = 7'b1110001;
    localparam logic [6:0] G_O = 7'b0000001;
    localparam logic [6:0] G_B = 7'b1111111;
    localparam logic [34:0] HELLO = {G_H, G_E, G_L, G_L, G_O};
    localparam logic [34:0] DARK  = {G_B, G_B, G_B, G_B, G_B};

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] SW;
`ifdef HELLO_SEQ_FREEZE_EN
    logic       FREEZE = 1'b0;
`endif
    logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4;

    int checks = 0;
    int errors = 0;

    // Reference model: the message as a string of glyphs, a window start, a visibility flag.
    logic [3:0]  m_sw_seen;
    logic [3:0]  m_sw_acted;
    int          m_cnt;
    int          m_mode;
    bit          m_demo_blink;
    int          m_pos;
    bit          m_vis;
    int          m_step;
    bit          m_live;
    logic [34:0] m_exp;

    hello_display_sequencer #(.TICK_DIV(TDIV), .DEMO_BLINK_TICKS(DBT)) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .SW       (SW),
`ifdef HELLO_SEQ_FREEZE_EN
        .FREEZE   (FREEZE),
`endif
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] msg_char(input int i);
        logic [6:0] msg [8];
        msg = '{G_H, G_E, G_L, G_L, G_O, G_B, G_B, G_B};
        return msg[i % 8];
    endfunction

    function automatic logic [34:0] render(input bit live, input bit vis, input int pos);
        logic [34:0] r;
        r = DARK;
        if (live && vis) begin
            // leftmost digit shows message character pos, then pos+1, ...
            r = {msg_char(pos), msg_char(pos + 1), msg_char(pos + 2),
                 msg_char(pos + 3), msg_char(pos + 4)};
        end
        return r;
    endfunction

    task automatic model_edge(input logic [3:0] sw, input bit rst);
        bit changed;
        bit tick;
        int period;
        if (rst) begin
            m_sw_seen = 4'd0; m_sw_acted = 4'd0; m_cnt = 0; m_mode = 0;
            m_demo_blink = 0; m_pos = 0; m_vis = 1; m_step = 0; m_live = 0;
            m_exp = DARK;
            return;
        end
        m_exp   = render(m_live, m_vis, m_pos);
        changed = (m_sw_seen != m_sw_acted);
        period  = TDIV / (1 << m_sw_seen[1:0]);
        tick    = !changed && (m_cnt + 1 == period);
        m_cnt   = (changed || tick) ? 0 : m_cnt + 1;
        if (m_sw_seen[3:2] != m_sw_acted[3:2]) begin
            m_mode = int'(m_sw_seen[3:2]);
            m_demo_blink = 0; m_pos = 0; m_vis = 1; m_step = 0;
        end else if (tick) begin
            if (m_mode == 1) begin
                m_vis = !m_vis;
            end else if (m_mode == 2) begin
                m_pos = (m_pos + 1) % 8;
            end else if (m_mode == 3 && !m_demo_blink) begin
                m_pos = (m_pos + 1) % 8;
                if (m_pos == 0) begin
                    m_demo_blink = 1; m_step = 0; m_vis = 1;
                end
            end else if (m_mode == 3) begin
                m_step = m_step + 1;
                m_vis  = !m_vis;
                if (m_step == DBT) begin
                    m_demo_blink = 0; m_vis = 1; m_pos = 0; m_step = 0;
                end
            end
        end
        m_sw_acted = m_sw_seen;
        m_sw_seen  = sw;
        m_live     = 1;
    endtask

    task automatic step(input logic [3:0] sw, input bit rst, input string tag);
        logic [34:0] act;
        SW    = sw;
        RESET = rst;
        @(posedge clk);
        model_edge(sw, rst);
        #1;
        act = {HEX4, HEX3, HEX2, HEX1, HEX0};
        checks++;
        assert (act === m_exp) else begin
            errors++;
            $error("FAIL %s hex=%h expected=%h", tag, act, m_exp);
        end
    endtask

    task automatic run(input int n, input logic [3:0] sw, input string tag);
        for (int i = 0; i < n; i++) step(sw, 1'b0, tag);
    endtask

    task automatic check_const(input string tag, input logic [34:0] want);
        logic [34:0] act;
        act = {HEX4, HEX3, HEX2, HEX1, HEX0};
        checks++;
        assert (act === want) else begin
            errors++;
            $error("FAIL %s hex=%h expected=%h", tag, act, want);
        end
    endtask

    task automatic check_found(input string tag, input bit found);
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s found=%0d expected=1", tag, found);
        end
    endtask

    initial begin
        bit found;
        logic [3:0] rsw;
        int len;

        // reset hold, then static HELLO
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, "reset");
        check_const("reset_dark", DARK);
        run(2, 4'b0000, "release");
        check_const("release_hello", HELLO);
        run(200, 4'b0000, "static");
        check_const("static_hello", HELLO);

        // blink at slowest and fastest speed
        run(80, 4'b0100, "blink_s0");
        run(24, 4'b0111, "blink_s3");

        // scroll with window positions at 1, 5 and wrap
        run(20, 4'b1000, "scroll");
        check_const("scroll_1", {G_E, G_L, G_L, G_O, G_B});
        run(64, 4'b1000, "scroll");
        check_const("scroll_5", {G_B, G_B, G_B, G_H, G_E});
        run(48, 4'b1000, "scroll");
        check_const("scroll_wrap", HELLO);

        // mode change landing on the same cycle as a tick at pos=3
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_pos == 3 && m_cnt == TDIV - 2) found = 1;
            else step(4'b1000, 1'b0, "to_pos3");
        end
        check_found("pos3_reached", found);
        run(3, 4'b0000, "mode_chg");
        check_const("mode_chg_hello", HELLO);
        run(40, 4'b0000, "mode_chg_hold");
        check_const("mode_chg_stable", HELLO);

        // demo: full scroll, blink run, scroll again
        run(16 * (8 + DBT + 3) + 4, 4'b1100, "demo");

        // reset in the middle of the demo blink phase
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_demo_blink && m_step == 2) found = 1;
            else step(4'b1100, 1'b0, "to_demo_blink");
        end
        check_found("demo_blink_reached", found);
        step(4'b0000, 1'b1, "mid_reset");
        check_const("mid_reset_dark", DARK);
        run(2, 4'b0000, "post_reset");
        check_const("post_reset_hello", HELLO);
        run(20, 4'b0000, "post_reset");

        // randomized switch changes with occasional reset
        for (int s = 0; s < 60; s++) begin
            rsw = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 80);
            if ($urandom_range(0, 14) == 0) step(rsw, 1'b1, "rand_reset");
            run(len, rsw, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
